// File: rtl/bin2rns_seq.sv
// Sequential binary-to-RNS forward converter: MSB-first shift-and-reduce, one
// input bit per cycle, residues for up to four compile-time moduli.
module bin2rns_seq #(
  parameter int DYN_SIZE = 16,
  parameter int MOD_SIZE = 5,
  parameter int NUM_MOD  = 4,
  parameter int MOD_0    = 32,
  parameter int MOD_1    = 31,
  parameter int MOD_2    = 21,
  parameter int MOD_3    = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DYN_SIZE-1:0]     N,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*MOD_SIZE-1:0]   out_res,
  output logic                    busy
);

  localparam int CNT_W = (DYN_SIZE > 2) ? $clog2(DYN_SIZE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

  state_t                     state_q, state_d;
  logic [DYN_SIZE-1:0]        shift_q, shift_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [3:0][MOD_SIZE-1:0]   res_q, res_d;

  function automatic logic [MOD_SIZE:0] mod_of(input int k);
    case (k)
      0:       mod_of = (MOD_SIZE+1)'(MOD_0);
      1:       mod_of = (MOD_SIZE+1)'(MOD_1);
      2:       mod_of = (MOD_SIZE+1)'(MOD_2);
      default: mod_of = (MOD_SIZE+1)'(MOD_3);
    endcase
  endfunction

  // r < m guarantees 2r+b < 2m, so a single conditional subtract reduces fully.
  function automatic logic [MOD_SIZE-1:0] reduce_step(input logic [MOD_SIZE-1:0] r,
                                                      input logic                b,
                                                      input logic [MOD_SIZE:0]   m);
    logic [MOD_SIZE:0] t;
    t = {r, b};
    if (t >= m) t = t - m;
    reduce_step = t[MOD_SIZE-1:0];
  endfunction

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          shift_d = N;
          res_d   = '0;
          cnt_d   = CNT_W'(DYN_SIZE - 1);
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        shift_d = {shift_q[DYN_SIZE-2:0], 1'b0};
        // Channels at or above NUM_MOD are never written and stay at zero.
        for (int k = 0; k < 4; k++) begin
          if (k < NUM_MOD) res_d[k] = reduce_step(res_q[k], shift_q[DYN_SIZE-1], mod_of(k));
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_res   = res_q;

endmodule
